// File: rtl/fire_input_conditioner_if.sv
// Board-side bus of the fire input conditioner: raw inputs in, registered selection and fire out.
// The shots counter signal exists only when SHOT_COUNT_EN is defined.
interface fire_input_conditioner_if;
    localparam int unsigned SW_W   = 4;
    localparam int unsigned SHOT_W = 8;

    logic            fire_btn;
    logic [SW_W-1:0] sw_raw;
    logic            nrow_raw;
    logic [SW_W-1:0] row;
    logic [SW_W-1:0] col;
    logic            error;
    logic            fire;
`ifdef SHOT_COUNT_EN
    logic [SHOT_W-1:0] shots;

    modport master (
        output fire_btn, sw_raw, nrow_raw,
        input  row, col, error, fire, shots
    );
    modport slave (
        input  fire_btn, sw_raw, nrow_raw,
        output row, col, error, fire, shots
    );
`else
    modport master (
        output fire_btn, sw_raw, nrow_raw,
        input  row, col, error, fire
    );
    modport slave (
        input  fire_btn, sw_raw, nrow_raw,
        output row, col, error, fire
    );
`endif
endinterface

// File: rtl/fire_input_conditioner.sv
// Synchronises and debounces the fire button, select switches and mode switch, then drives the
// one-hot row/col enables, error flag and a one-cycle fire pulse. Optional: SHOT_COUNT_EN.
module fire_input_conditioner #(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    fire_input_conditioner_if.slave   bus
);
    localparam int unsigned SW_W     = 4;
    localparam int unsigned N_IN     = SW_W + 2;
    localparam int unsigned FIRE_IDX = SW_W;
    localparam int unsigned NROW_IDX = SW_W + 1;
    localparam int unsigned ONES_W   = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic [N_IN-1:0]   raw_c;
    logic [N_IN-1:0]   meta;
    logic [N_IN-1:0]   sync;
    logic [N_IN-1:0]   stable;
    logic [SW_W-1:0]   sw_db;
    logic              fire_db;
    logic              nrow_db;
    logic [ONES_W-1:0] ones;
    logic              valid_c;
    logic              err_c;
    state_t            state;
    state_t            state_next;
    logic [SW_W-1:0]   row_q;
    logic [SW_W-1:0]   col_q;
    logic              error_q;
    logic              fire_q;

    assign raw_c = {bus.nrow_raw, bus.fire_btn, bus.sw_raw};

    // Two-flop synchroniser for every asynchronous board input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw_c;
            sync <= meta;
        end
    end

    // Per-input debouncer: a level is committed only after DB_CYCLES consecutive differing samples
    for (genvar i = 0; i < N_IN; i++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             level;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync[i] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign stable[i] = level;
    end

    assign sw_db   = stable[SW_W-1:0];
    assign fire_db = stable[FIRE_IDX];
    assign nrow_db = stable[NROW_IDX];

    // Selection decode: exactly one switch up is a legal target
    always_comb begin
        ones = '0;
        for (int i = 0; i < SW_W; i++) begin
            ones = ones + ONES_W'(sw_db[i]);
        end
    end

    assign valid_c = (ones == ONES_W'(1));
    assign err_c   = (ones > ONES_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Press tracking: one pulse per press, and a rejected press must be released before retrying
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (fire_db && valid_c) begin
                    state_next = FIRE;
                end else if (fire_db) begin
                    state_next = HOLD;
                end
            end
            FIRE: state_next = HOLD;
            HOLD: begin
                if (!fire_db) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fire and row/col load on the same edge from the same decode, so a pulse never sees a stale target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q   <= '0;
            col_q   <= '0;
            error_q <= 1'b0;
            fire_q  <= 1'b0;
        end else begin
            error_q <= err_c;
            fire_q  <= (state_next == FIRE);
            if (err_c) begin
                row_q <= '0;
                col_q <= '0;
            end else if (!nrow_db) begin
                row_q <= sw_db;
                col_q <= '0;
            end else begin
                row_q <= '0;
                col_q <= sw_db;
            end
        end
    end

    assign bus.row   = row_q;
    assign bus.col   = col_q;
    assign bus.error = error_q;
    assign bus.fire  = fire_q;

`ifdef SHOT_COUNT_EN
    localparam int unsigned SHOT_W = 8;

    logic [SHOT_W-1:0] shots_q;

    // Saturating count of emitted fire pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shots_q <= '0;
        end else if (fire_q && (shots_q != '1)) begin
            shots_q <= shots_q + SHOT_W'(1);
        end
    end

    assign bus.shots = shots_q;
`endif

endmodule

// File: tb/tb_fire_input_conditioner.sv
// Bench for fire_input_conditioner with a short debounce window; a behavioural model is checked
// every cycle, plus literal latency and reset checks. Define SHOT_COUNT_EN to test the counter.
module tb_fire_input_conditioner;
    localparam int unsigned DB = 4;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic reset;

    fire_input_conditioner_if bus ();

    fire_input_conditioner #(
        .DB_CYCLES (DB),
        .CNT_W     (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulses       = 0;
    logic [3:0] fire_row = '0;
    logic [3:0] fire_col = '0;

    task automatic check(input string name, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: a debounced level flips once the last DB synchronised samples all disagree
    logic [7:0][5:0] hist;
    logic [5:0]      db;
    logic [3:0]      m_row, m_col;
    logic            m_err, m_fire, handled;
    logic [7:0]      m_shots;
    logic [5:0]      raw_v;

    assign raw_v = {bus.nrow_raw, bus.fire_btn, bus.sw_raw};

    function automatic logic [5:0] db_next(input logic [5:0] d, input logic [7:0][5:0] h);
        logic [5:0] r;
        logic       all_diff;
        r = d;
        for (int b = 0; b < 6; b++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= int'(DB); j++) begin
                if (h[j][b] == d[b]) all_diff = 1'b0;
            end
            if (all_diff) r[b] = ~d[b];
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist    <= '0;
            db      <= '0;
            m_row   <= '0;
            m_col   <= '0;
            m_err   <= 1'b0;
            m_fire  <= 1'b0;
            handled <= 1'b0;
            m_shots <= '0;
        end else begin
            if ($countones(db[3:0]) > 1) begin
                m_err <= 1'b1;
                m_row <= '0;
                m_col <= '0;
            end else begin
                m_err <= 1'b0;
                m_row <= db[5] ? 4'b0000 : db[3:0];
                m_col <= db[5] ? db[3:0] : 4'b0000;
            end
            m_fire  <= !handled && db[4] && ($countones(db[3:0]) == 1);
            handled <= db[4] || m_fire;
            m_shots <= (m_fire && m_shots != 8'hFF) ? m_shots + 8'd1 : m_shots;
            hist    <= {hist[6:0], raw_v};
            db      <= db_next(db, hist);
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        check("cycle_row_col_err_fire", int'({bus.row, bus.col, bus.error, bus.fire}),
              int'({m_row, m_col, m_err, m_fire}));
`ifdef SHOT_COUNT_EN
        check("cycle_shots", int'(bus.shots), int'(m_shots));
`endif
        if (bus.fire) begin
            pulses++;
            fire_row = bus.row;
            fire_col = bus.col;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({bus.row, bus.col, bus.error, bus.fire}), 0);
`ifdef SHOT_COUNT_EN
        check({name, "_shots"}, int'(bus.shots), 0);
`endif
    endtask

`ifdef SHOT_COUNT_EN
    task automatic press();
        bus.fire_btn = 1'b1;
        cyc(8);
        bus.fire_btn = 1'b0;
        cyc(8);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int p1;
        bit seen;
        reset        = 1'b0;
        bus.fire_btn = 1'b0;
        bus.sw_raw   = 4'b0000;
        bus.nrow_raw = 1'b0;
        #1 reset = 1'b1;
        #1 check_all_zero("reset_state");
        cyc(3);
        reset = 1'b0;
        cyc(2);

        // Row select latency and mode switch
        bus.sw_raw = 4'b0010;
        cyc(6);
        check("row_before_latency", int'(bus.row), 0);
        cyc(1);
        check("row_after_7_edges", int'(bus.row), 4'b0010);
        check("col_row_mode", int'(bus.col), 0);
        check("error_single", int'(bus.error), 0);
        bus.nrow_raw = 1'b1;
        cyc(7);
        check("col_after_mode", int'(bus.col), 4'b0010);
        check("row_after_mode", int'(bus.row), 0);

        // Bouncy button yields exactly one pulse 7 edges after the last raw edge
        bus.nrow_raw = 1'b0;
        bus.sw_raw   = 4'b0001;
        cyc(10);
        for (int k = 0; k < 10; k++) begin
            bus.fire_btn = ~bus.fire_btn;
            cyc(2);
        end
        p0 = pulses;
        bus.fire_btn = 1'b1;
        cyc(6);
        check("bounce_no_early_fire", int'(bus.fire), 0);
        check("bounce_no_pulse_yet", pulses - p0, 0);
        cyc(1);
        check("bounce_fire_at_7", int'(bus.fire), 1);
        check("bounce_fire_row", int'(bus.row), 4'b0001);
        cyc(5);
        check("bounce_one_pulse", pulses - p0, 1);

        // Illegal selection blocks fire; legal column selection fires
        bus.fire_btn = 1'b0;
        cyc(10);
        bus.sw_raw = 4'b0110;
        cyc(8);
        check("multi_error", int'(bus.error), 1);
        check("multi_row_col", int'({bus.row, bus.col}), 0);
        p0 = pulses;
        bus.fire_btn = 1'b1;
        cyc(12);
        check("rejected_press", pulses - p0, 0);
        bus.fire_btn = 1'b0;
        cyc(10);
        bus.sw_raw   = 4'b0100;
        bus.nrow_raw = 1'b1;
        cyc(8);
        bus.fire_btn = 1'b1;
        cyc(10);
        check("col_press_pulse", pulses - p0, 1);
        check("col_press_col", int'(fire_col), 4'b0100);
        check("col_press_row", int'(fire_row), 0);

        // Long hold gives one pulse; short switch glitch is filtered
        bus.fire_btn = 1'b0;
        cyc(10);
        bus.nrow_raw = 1'b0;
        bus.sw_raw   = 4'b1000;
        cyc(8);
        p0 = pulses;
        bus.fire_btn = 1'b1;
        cyc(500);
        bus.sw_raw = 4'b0000;
        cyc(3);
        bus.sw_raw = 4'b1000;
        cyc(10);
        check("glitch_row_kept", int'(bus.row), 4'b1000);
        cyc(487);
        check("long_hold_one_pulse", pulses - p0, 1);
        bus.fire_btn = 1'b0;
        cyc(10);
        bus.fire_btn = 1'b1;
        cyc(10);
        check("second_press_pulse", pulses - p0, 2);

        // Reset during the fire cycle clears outputs immediately
        bus.fire_btn = 1'b0;
        cyc(10);
        p0 = pulses;
        bus.fire_btn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.fire) seen = 1'b1;
        end
        check("fire_seen_before_reset", int'(seen), 1);
        #2 reset = 1'b1;
        #1 check_all_zero("reset_in_fire");
        bus.fire_btn = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(12);
        check("no_pulse_after_fire_reset", pulses - p0, 1);

        // Reset during hold, released with the button up
        bus.fire_btn = 1'b1;
        cyc(15);
        p1 = pulses;
        check("hold_press_pulse", p1 - p0, 2);
        check("hold_row_set", int'(bus.row), 4'b1000);
        #2 reset = 1'b1;
        #1 check_all_zero("reset_in_hold");
        bus.fire_btn = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(15);
        check("no_pulse_after_hold_reset", pulses - p1, 0);

`ifdef SHOT_COUNT_EN
        // Shot counter: valid presses count, rejected ones do not, saturates at 255
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.nrow_raw = 1'b0;
        bus.sw_raw   = 4'b0001;
        cyc(10);
        for (int k = 0; k < 3; k++) press();
        bus.sw_raw = 4'b0011;
        cyc(8);
        press();
        bus.sw_raw = 4'b0001;
        cyc(8);
        check("shots_three", int'(bus.shots), 3);
        for (int k = 0; k < 260; k++) press();
        check("shots_saturate", int'(bus.shots), 255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
